// File: rtl/ssooo_pkg.sv
// Shared definitions for the decoded-instruction path: field widths,
// the packed entry layout and helpers to build/split an entry.
package ssooo_pkg;

  localparam int OPC_W   = 12;
  localparam int REG_W   = 5;
  localparam int IMM_W   = 16;
  localparam int ADDR_W  = 26;
  localparam int PC_W    = 32;
  localparam int ENTRY_W = OPC_W + 4 * REG_W + IMM_W + ADDR_W + PC_W;

  // Field order is MSB first: opcode, rs, rt, rd, shamt, imm, addr, pc.
  typedef struct packed {
    logic [OPC_W-1:0]  opcode;
    logic [REG_W-1:0]  rs;
    logic [REG_W-1:0]  rt;
    logic [REG_W-1:0]  rd;
    logic [REG_W-1:0]  shamt;
    logic [IMM_W-1:0]  imm;
    logic [ADDR_W-1:0] addr;
    logic [PC_W-1:0]   pc;
  } entry_t;

  // Concatenate individual decode fields into one storage word.
  function automatic logic [ENTRY_W-1:0] pack_entry(
    input logic [OPC_W-1:0]  opcode,
    input logic [REG_W-1:0]  rs,
    input logic [REG_W-1:0]  rt,
    input logic [REG_W-1:0]  rd,
    input logic [REG_W-1:0]  shamt,
    input logic [IMM_W-1:0]  imm,
    input logic [ADDR_W-1:0] addr,
    input logic [PC_W-1:0]   pc
  );
    return {opcode, rs, rt, rd, shamt, imm, addr, pc};
  endfunction

  // Reinterpret a storage word as named fields.
  function automatic entry_t unpack_entry(input logic [ENTRY_W-1:0] word);
    return entry_t'(word);
  endfunction

endpackage

// File: rtl/decoded_inst_buffer_ram.sv
// Register-array storage for the decoded instruction buffer: one
// synchronous write port, one combinational read port, no reset.
module decoded_inst_ram
  import ssooo_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic               clk_i,
  input  logic               wr_en_i,
  input  logic [PTR_W-1:0]   wr_addr_i,
  input  logic [ENTRY_W-1:0] wr_data_i,
  input  logic [PTR_W-1:0]   rd_addr_i,
  output logic [ENTRY_W-1:0] rd_data_o
);

  logic [ENTRY_W-1:0] mem_q [DEPTH];

  // Capture the pushed entry at the write pointer; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/decoded_inst_buffer.sv
// FIFO holding decoded instructions between decode and dispatch/rename.
// Valid/ready on both sides, one push and one pop per cycle, and a
// single-cycle flush for redirects. No bypass: a push is visible the
// cycle after it is written, and a full buffer never accepts even when
// popping in the same cycle.
module decoded_inst_buffer
  import ssooo_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,

  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OPC_W-1:0]  in_opcode,
  input  logic [REG_W-1:0]  in_rs,
  input  logic [REG_W-1:0]  in_rt,
  input  logic [REG_W-1:0]  in_rd,
  input  logic [REG_W-1:0]  in_shamt,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [PC_W-1:0]   in_pc,

  output logic              out_valid,
  input  logic              out_ready,
  output logic [OPC_W-1:0]  out_opcode,
  output logic [REG_W-1:0]  out_rs,
  output logic [REG_W-1:0]  out_rt,
  output logic [REG_W-1:0]  out_rd,
  output logic [REG_W-1:0]  out_shamt,
  output logic [IMM_W-1:0]  out_imm,
  output logic [ADDR_W-1:0] out_addr,
  output logic [PC_W-1:0]   out_pc,

  output logic [PTR_W:0]    count
);

  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]     count_q, count_d;
  logic               push, pop;
  logic [ENTRY_W-1:0] wr_word;
  logic [ENTRY_W-1:0] head_word;
  entry_t             head;

  assign in_ready  = (count_q != FULL_CNT);
  assign out_valid = (count_q != '0);
  assign count     = count_q;

  // Flush suppresses both sides so a redirect always wins.
  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  assign wr_word = pack_entry(in_opcode, in_rs, in_rt, in_rd, in_shamt,
                              in_imm, in_addr, in_pc);

  decoded_inst_ram #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_ram (
    .clk_i     (clk),
    .wr_en_i   (push),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (wr_word),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (head_word)
  );

  // Compute next pointers and occupancy from this cycle's push/pop/flush.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers; reset empties the buffer at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Present the head entry, or all zeros when nothing is buffered.
  always_comb begin
    head       = unpack_entry(head_word);
    out_opcode = '0;
    out_rs     = '0;
    out_rt     = '0;
    out_rd     = '0;
    out_shamt  = '0;
    out_imm    = '0;
    out_addr   = '0;
    out_pc     = '0;
    if (out_valid) begin
      out_opcode = head.opcode;
      out_rs     = head.rs;
      out_rt     = head.rt;
      out_rd     = head.rd;
      out_shamt  = head.shamt;
      out_imm    = head.imm;
      out_addr   = head.addr;
      out_pc     = head.pc;
    end
  end

endmodule

// File: tb/tb_decoded_inst_buffer.sv
// Directed bench for decoded_inst_buffer: reset, single push/pop, fill to
// full with a held push, streaming through the pointer wrap, flush, and
// an asynchronous reset between edges.
module tb_decoded_inst_buffer;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_opcode;
  logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
  logic [15:0] in_imm;
  logic [25:0] in_addr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_opcode;
  logic [4:0]  out_rs, out_rt, out_rd, out_shamt;
  logic [15:0] out_imm;
  logic [25:0] out_addr;
  logic [31:0] out_pc;
  logic [2:0]  count;

  int passCount  = 0;
  int checkCount = 0;

  decoded_inst_buffer #(.DEPTH(4), .PTR_W(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opcode  (in_opcode),
    .in_rs      (in_rs),
    .in_rt      (in_rt),
    .in_rd      (in_rd),
    .in_shamt   (in_shamt),
    .in_imm     (in_imm),
    .in_addr    (in_addr),
    .in_pc      (in_pc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_opcode (out_opcode),
    .out_rs     (out_rs),
    .out_rt     (out_rt),
    .out_rd     (out_rd),
    .out_shamt  (out_shamt),
    .out_imm    (out_imm),
    .out_addr   (out_addr),
    .out_pc     (out_pc),
    .count      (count)
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one cycle's worth of inputs; unlisted fields get fixed markers.
  task automatic applyStimulus(input logic v, input logic fl, input logic ordy,
                               input logic [31:0] pc, input logic [11:0] opc,
                               input logic [4:0] rs);
    in_valid  = v;
    flush     = fl;
    out_ready = ordy;
    in_pc     = pc;
    in_opcode = opc;
    in_rs     = rs;
    in_rt     = 5'd4;
    in_rd     = 5'd5;
    in_shamt  = 5'd6;
    in_imm    = 16'hBEEF;
    in_addr   = 26'h2ABCDEF;
  endtask

  // Compare one observed value with its expected value.
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Advance past the next rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 12'h0, 5'd0);
    tick();
    checkOutput("rst_count", 32'(count), 32'd0);
    tick();
    rst = 1'b1;
    tick();
    checkOutput("idle_count", 32'(count), 32'd0);
    checkOutput("idle_out_valid", 32'(out_valid), 32'd0);
    checkOutput("idle_in_ready", 32'(in_ready), 32'd1);
    checkOutput("idle_out_pc", out_pc, 32'd0);

    // Single push, held at the output, then popped.
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h10, 12'h020, 5'd3);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 12'h0, 5'd0);
    checkOutput("single_valid", 32'(out_valid), 32'd1);
    checkOutput("single_pc", out_pc, 32'h10);
    checkOutput("single_rs", 32'(out_rs), 32'd3);
    checkOutput("single_opcode", 32'(out_opcode), 32'h020);
    checkOutput("single_rt", 32'(out_rt), 32'd4);
    checkOutput("single_rd", 32'(out_rd), 32'd5);
    checkOutput("single_shamt", 32'(out_shamt), 32'd6);
    checkOutput("single_imm", 32'(out_imm), 32'hBEEF);
    checkOutput("single_addr", 32'(out_addr), 32'h2ABCDEF);
    checkOutput("single_count", 32'(count), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0, 12'h0, 5'd0);
    tick();
    checkOutput("single_pop_count", 32'(count), 32'd0);
    checkOutput("single_pop_valid", 32'(out_valid), 32'd0);
    checkOutput("empty_pc_zero", out_pc, 32'd0);

    // Fill to full, hold a fifth push, then drain in order.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 32'(i), 12'h001, 5'd1);
      tick();
    end
    checkOutput("full_count", 32'(count), 32'd4);
    checkOutput("full_in_ready", 32'(in_ready), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd4, 12'h001, 5'd1);
    tick();
    checkOutput("full_hold_count", 32'(count), 32'd4);
    checkOutput("full_hold_pc", out_pc, 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'd4, 12'h001, 5'd1);
    tick();
    checkOutput("full_pop_count", 32'(count), 32'd3);
    checkOutput("full_pop_in_ready", 32'(in_ready), 32'd1);
    checkOutput("drain_pc1", out_pc, 32'd1);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b1, 32'd0, 12'h0, 5'd0);
    checkOutput("pushpop_full_count", 32'(count), 32'd3);
    for (int k = 2; k <= 4; k++) begin
      checkOutput("drain_pc", out_pc, 32'(k));
      tick();
    end
    checkOutput("drain_count", 32'(count), 32'd0);
    checkOutput("drain_valid", 32'(out_valid), 32'd0);

    // Steady push+pop at count 2 across the pointer wrap.
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd0, 12'h002, 5'd2);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'd1, 12'h002, 5'd2);
    tick();
    checkOutput("stream_start_count", 32'(count), 32'd2);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 32'(i + 2), 12'h002, 5'd2);
      checkOutput("stream_pc", out_pc, 32'(i));
      tick();
      checkOutput("stream_count", 32'(count), 32'd2);
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 32'd0, 12'h0, 5'd0);
    checkOutput("stream_tail_pc10", out_pc, 32'd10);
    tick();
    checkOutput("stream_tail_pc11", out_pc, 32'd11);
    tick();
    checkOutput("stream_end_count", 32'(count), 32'd0);

    // Flush at count 3 with a concurrent push and pop.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 32'(32'h20 + i), 12'h003, 5'd7);
      tick();
    end
    checkOutput("preflush_count", 32'(count), 32'd3);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h23, 12'h003, 5'd7);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 12'h0, 5'd0);
    checkOutput("flush_count", 32'(count), 32'd0);
    checkOutput("flush_valid", 32'(out_valid), 32'd0);
    checkOutput("flush_in_ready", 32'(in_ready), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h40, 12'h004, 5'd8);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 12'h0, 5'd0);
    checkOutput("postflush_valid", 32'(out_valid), 32'd1);
    checkOutput("postflush_pc", out_pc, 32'h40);

    // Reach count 3, then reset between edges.
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h41, 12'h004, 5'd8);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h42, 12'h004, 5'd8);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 12'h0, 5'd0);
    checkOutput("prereset_count", 32'(count), 32'd3);
    #3;
    rst = 1'b0;
    #1;
    checkOutput("async_rst_count", 32'(count), 32'd0);
    checkOutput("async_rst_valid", 32'(out_valid), 32'd0);
    checkOutput("async_rst_pc", out_pc, 32'd0);
    checkOutput("async_rst_in_ready", 32'(in_ready), 32'd1);
    #2;
    rst = 1'b1;
    tick();
    checkOutput("post_rst_count", 32'(count), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h50, 12'h005, 5'd9);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 12'h0, 5'd0);
    checkOutput("post_rst_pc", out_pc, 32'h50);
    checkOutput("post_rst_push_count", 32'(count), 32'd1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
